// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch back end.
package fetch_pkg;

  localparam int FETCH_AW     = 11;
  localparam int FETCH_IW     = 32;
  localparam int FETCH_STAT_W = 16;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_IW-1:0] instr;
  } fetch_entry_t;

  function automatic logic [FETCH_STAT_W-1:0] sat_inc(input logic [FETCH_STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch back-end bus: PC/imem side, branch port to the PC, and decode handshake.
// Handshake: an entry transfers to decode on a cycle where dec_valid && dec_ready;
// dec_valid never depends on dec_ready, and dec_* stay stable until accepted or flushed.
interface fetch_queue_if #(
  parameter int AW = fetch_pkg::FETCH_AW,
  parameter int IW = fetch_pkg::FETCH_IW
);
  logic [AW-1:0] pc_cnt;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          branch_valid;
  logic [AW-1:0] branch_address;
  logic          ex_redirect;
  logic [AW-1:0] ex_target;
  logic          dec_valid;
  logic          dec_ready;
  logic [IW-1:0] dec_instr;
  logic [AW-1:0] dec_pc;

  modport slave (
    input  pc_cnt, imem_data, ex_redirect, ex_target, dec_ready,
    output imem_addr, branch_valid, branch_address, dec_valid, dec_instr, dec_pc
  );

  modport master (
    output pc_cnt, imem_data, ex_redirect, ex_target, dec_ready,
    input  imem_addr, branch_valid, branch_address, dec_valid, dec_instr, dec_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush beats push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   i_push,
  input  logic   i_pop,
  input  logic   i_flush,
  input  entry_t i_data,
  output entry_t o_data,
  output logic   o_full,
  output logic   o_empty
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  entry_t        r_mem [DEPTH];
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
  // A full queue may take a push only when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[PW-2:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= r_rd_ptr;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && !i_flush && w_do_push) r_mem[r_wr_ptr[PW-2:0]] <= i_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch back end: redirect/replay control of the PC branch port plus decode queue.
// Optional counters are enabled by defining FETCH_STATS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int AW    = FETCH_AW,
  parameter int IW    = FETCH_IW,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  fetch_queue_if.slave            bus
`ifdef FETCH_STATS_EN
  ,
  output logic [FETCH_STAT_W-1:0] stat_fetched,
  output logic [FETCH_STAT_W-1:0] stat_replays,
  output logic [FETCH_STAT_W-1:0] stat_flushes
`endif
);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;

  entry_t w_cand;
  entry_t w_head;
  logic   w_full;
  logic   w_empty;
  logic   w_dec_valid;
  logic   w_pop;
  logic   w_flush;
  logic   w_replay;
  logic   w_push;

  assign w_cand = '{pc: bus.pc_cnt, instr: bus.imem_data};

  always_comb begin
    w_dec_valid = resetn && !w_empty && !bus.ex_redirect;
    w_pop       = w_dec_valid && bus.dec_ready;
    w_flush     = resetn && bus.ex_redirect;
    w_replay    = resetn && !bus.ex_redirect && w_full && !w_pop;
    w_push      = resetn && !bus.ex_redirect && !w_replay;
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_cand),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Replay reloads the current PC: the PC has no stall input, so this is its only hold.
  assign bus.branch_valid   = w_flush || w_replay;
  assign bus.branch_address = w_replay ? bus.pc_cnt : bus.ex_target;
  assign bus.imem_addr      = bus.pc_cnt;
  assign bus.dec_valid      = w_dec_valid;
  assign bus.dec_pc         = w_head.pc;
  assign bus.dec_instr      = w_head.instr;

`ifdef FETCH_STATS_EN
  logic [FETCH_STAT_W-1:0] r_stat_fetched;
  logic [FETCH_STAT_W-1:0] r_stat_replays;
  logic [FETCH_STAT_W-1:0] r_stat_flushes;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stat_fetched <= '0;
      r_stat_replays <= '0;
      r_stat_flushes <= '0;
    end else begin
      if (w_push)   r_stat_fetched <= sat_inc(r_stat_fetched);
      if (w_replay) r_stat_replays <= sat_inc(r_stat_replays);
      if (w_flush)  r_stat_flushes <= sat_inc(r_stat_flushes);
    end
  end

  assign stat_fetched = r_stat_fetched;
  assign stat_replays = r_stat_replays;
  assign stat_flushes = r_stat_flushes;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: models the PC register and imem, scoreboards decode output.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int AW    = FETCH_AW;
  localparam int IW    = FETCH_IW;
  localparam int DEPTH = 4;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.AW(AW), .IW(IW)) bus();

`ifdef FETCH_STATS_EN
  logic [FETCH_STAT_W-1:0] stat_fetched;
  logic [FETCH_STAT_W-1:0] stat_replays;
  logic [FETCH_STAT_W-1:0] stat_flushes;
`endif

  fetch_queue #(.AW(AW), .IW(IW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched (stat_fetched),
    .stat_replays (stat_replays),
    .stat_flushes (stat_flushes)
`endif
  );

  // PC register model: reset to 0, load on branch port, else increment.
  logic [AW-1:0] r_pc;
  always @(posedge clk) begin
    if (!resetn)                r_pc <= '0;
    else if (bus.branch_valid)  r_pc <= bus.branch_address;
    else                        r_pc <= r_pc + 1'b1;
  end
  assign bus.pc_cnt    = r_pc;
  assign bus.imem_data = IW'(bus.imem_addr) + IW'(32'h100);

  int total = 0;
  int bad   = 0;
  logic [AW+IW-1:0] exp_q[$];

  function automatic logic [AW+IW-1:0] exp_of(input logic [AW-1:0] pc);
    return {pc, IW'(pc) + IW'(32'h100)};
  endfunction

  // Scoreboard: every decode transfer must match the oldest expected entry.
  logic [AW+IW-1:0] sb_e;
  always @(negedge clk) begin
    if (resetn && bus.dec_valid && bus.dec_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, required no transfer", bus.dec_pc, bus.dec_instr);
      end else begin
        sb_e = exp_q.pop_front();
        if ({bus.dec_pc, bus.dec_instr} !== sb_e) begin
          bad++;
          $display("FAIL sb_data: got pc=%h instr=%h, required pc=%h instr=%h",
                   bus.dec_pc, bus.dec_instr, sb_e[AW+IW-1:IW], sb_e[IW-1:0]);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    resetn          = 1'b0;
    bus.ex_redirect = 1'b0;
    bus.ex_target   = '0;
    bus.dec_ready   = rdy;
    next_cycle();
    next_cycle();
    exp_q.delete();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; bus.ex_redirect = 1'b0; bus.ex_target = '0; bus.dec_ready = 1'b0;
    next_cycle();
    #2;
    total++; if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL rst_dec_valid: got %b required 0", bus.dec_valid); end
    total++; if (bus.branch_valid !== 1'b0) begin bad++; $display("FAIL rst_branch_valid: got %b required 0", bus.branch_valid); end
    next_cycle();
    resetn = 1'b1;
    #2;
    total++; if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL rst_empty: got dec_valid=%b required 0", bus.dec_valid); end
    total++; if (bus.imem_addr !== 11'h000) begin bad++; $display("FAIL rst_imem_addr: got %h required 000", bus.imem_addr); end
    next_cycle();
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back(exp_of(AW'(k)));
      #2;
      total++; if (bus.branch_valid !== 1'b0) begin bad++; $display("FAIL stream_bv c%0d: got %b required 0", k, bus.branch_valid); end
      total++; if (bus.dec_valid !== (k != 0)) begin bad++; $display("FAIL stream_dv c%0d: got %b required %b", k, bus.dec_valid, (k != 0)); end
      total++; if (bus.imem_addr !== AW'(k)) begin bad++; $display("FAIL stream_addr c%0d: got %h required %h", k, bus.imem_addr, AW'(k)); end
      next_cycle();
    end
    total++; if (exp_q.size() != 1) begin bad++; $display("FAIL stream_drain: got %0d pending required 1", exp_q.size()); end
  endtask

  task automatic test_fill_replay();
    do_reset(1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back(exp_of(AW'(k)));
      #2;
      total++; if (bus.branch_valid !== 1'b0) begin bad++; $display("FAIL fill_bv c%0d: got %b required 0", k, bus.branch_valid); end
      next_cycle();
    end
    for (int k = 0; k < 4; k++) begin
      #2;
      total++; if (bus.branch_valid !== 1'b1) begin bad++; $display("FAIL replay_bv r%0d: got %b required 1", k, bus.branch_valid); end
      total++; if (bus.branch_address !== 11'h004) begin bad++; $display("FAIL replay_ba r%0d: got %h required 004", k, bus.branch_address); end
      next_cycle();
    end
    bus.dec_ready = 1'b1;
    for (int k = 4; k < 10; k++) begin
      exp_q.push_back(exp_of(AW'(k)));
      #2;
      total++; if (bus.branch_valid !== 1'b0) begin bad++; $display("FAIL release_bv c%0d: got %b required 0", k, bus.branch_valid); end
      total++; if (bus.dec_valid !== 1'b1) begin bad++; $display("FAIL release_gap c%0d: got dec_valid=%b required 1", k, bus.dec_valid); end
      next_cycle();
    end
    total++; if (exp_q.size() != 4) begin bad++; $display("FAIL release_drain: got %0d pending required 4", exp_q.size()); end
  endtask

  task automatic test_flush();
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(exp_of(AW'(k)));
      next_cycle();
    end
    bus.ex_redirect = 1'b1;
    bus.ex_target   = 11'h200;
    exp_q.delete();
    #2;
    total++; if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL flush_dv: got %b required 0", bus.dec_valid); end
    total++; if (bus.branch_valid !== 1'b1) begin bad++; $display("FAIL flush_bv: got %b required 1", bus.branch_valid); end
    total++; if (bus.branch_address !== 11'h200) begin bad++; $display("FAIL flush_ba: got %h required 200", bus.branch_address); end
    next_cycle();
    bus.ex_redirect = 1'b0;
    bus.dec_ready   = 1'b1;
    exp_q.push_back(exp_of(11'h200));
    #2;
    total++; if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL flush_empty: got dec_valid=%b required 0", bus.dec_valid); end
    total++; if (bus.imem_addr !== 11'h200) begin bad++; $display("FAIL flush_target: got %h required 200", bus.imem_addr); end
`ifdef FETCH_STATS_EN
    total++; if (stat_flushes !== 16'd1) begin bad++; $display("FAIL stat_flushes: got %0d required 1", stat_flushes); end
    total++; if (stat_fetched !== 16'd3) begin bad++; $display("FAIL stat_fetched_flush: got %0d required 3", stat_fetched); end
`endif
    next_cycle();
    exp_q.push_back(exp_of(11'h201));
    #2;
    total++; if (bus.dec_pc !== 11'h200) begin bad++; $display("FAIL flush_head: got %h required 200", bus.dec_pc); end
    next_cycle();
    total++; if (exp_q.size() != 1) begin bad++; $display("FAIL flush_drain: got %0d pending required 1", exp_q.size()); end
  endtask

  task automatic test_redirect_full();
    do_reset(1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back(exp_of(AW'(k)));
      next_cycle();
    end
    #2;
    total++; if (bus.branch_address !== 11'h004) begin bad++; $display("FAIL rf_replay_ba: got %h required 004", bus.branch_address); end
    bus.ex_redirect = 1'b1;
    bus.ex_target   = 11'h050;
    exp_q.delete();
    #1;
    total++; if (bus.branch_address !== 11'h050) begin bad++; $display("FAIL rf_ba: got %h required 050", bus.branch_address); end
    total++; if (bus.branch_valid !== 1'b1) begin bad++; $display("FAIL rf_bv: got %b required 1", bus.branch_valid); end
    total++; if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL rf_dv: got %b required 0", bus.dec_valid); end
    next_cycle();
    bus.ex_redirect = 1'b0;
    exp_q.push_back(exp_of(11'h050));
    #2;
    total++; if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL rf_empty: got dec_valid=%b required 0", bus.dec_valid); end
    total++; if (bus.branch_valid !== 1'b0) begin bad++; $display("FAIL rf_bv_after: got %b required 0", bus.branch_valid); end
    next_cycle();
    bus.dec_ready = 1'b1;
    exp_q.push_back(exp_of(11'h051));
    #2;
    total++; if (bus.dec_valid !== 1'b1) begin bad++; $display("FAIL rf_head_valid: got %b required 1", bus.dec_valid); end
    next_cycle();
    total++; if (exp_q.size() != 1) begin bad++; $display("FAIL rf_drain: got %0d pending required 1", exp_q.size()); end
  endtask

  task automatic test_pc_wrap();
    logic [AW-1:0] pcs [4];
    pcs = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    do_reset(1'b1);
    bus.ex_redirect = 1'b1;
    bus.ex_target   = 11'h7FE;
    #2;
    total++; if (bus.branch_address !== 11'h7FE) begin bad++; $display("FAIL wrap_ba: got %h required 7fe", bus.branch_address); end
    next_cycle();
    bus.ex_redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(exp_of(pcs[k]));
      #2;
      total++; if (bus.imem_addr !== pcs[k]) begin bad++; $display("FAIL wrap_addr c%0d: got %h required %h", k, bus.imem_addr, pcs[k]); end
      next_cycle();
    end
    total++; if (exp_q.size() != 1) begin bad++; $display("FAIL wrap_drain: got %0d pending required 1", exp_q.size()); end
  endtask

  task automatic test_reset_midop();
    do_reset(1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back(exp_of(AW'(k)));
      next_cycle();
    end
    next_cycle();
    next_cycle();
`ifdef FETCH_STATS_EN
    total++; if (stat_fetched !== 16'd4) begin bad++; $display("FAIL stat_fetched_pre: got %0d required 4", stat_fetched); end
    total++; if (stat_replays !== 16'd2) begin bad++; $display("FAIL stat_replays_pre: got %0d required 2", stat_replays); end
`endif
    resetn = 1'b0;
    exp_q.delete();
    #2;
    total++; if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL midrst_dv: got %b required 0", bus.dec_valid); end
    total++; if (bus.branch_valid !== 1'b0) begin bad++; $display("FAIL midrst_bv: got %b required 0", bus.branch_valid); end
    next_cycle();
    resetn        = 1'b1;
    bus.dec_ready = 1'b1;
    exp_q.push_back(exp_of(11'h000));
    #2;
    total++; if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL midrst_empty: got dec_valid=%b required 0", bus.dec_valid); end
`ifdef FETCH_STATS_EN
    total++; if (stat_fetched !== 16'd0) begin bad++; $display("FAIL stat_fetched_clr: got %0d required 0", stat_fetched); end
    total++; if (stat_replays !== 16'd0) begin bad++; $display("FAIL stat_replays_clr: got %0d required 0", stat_replays); end
    total++; if (stat_flushes !== 16'd0) begin bad++; $display("FAIL stat_flushes_clr: got %0d required 0", stat_flushes); end
`endif
    next_cycle();
    exp_q.push_back(exp_of(11'h001));
    #2;
    total++; if (bus.dec_valid !== 1'b1) begin bad++; $display("FAIL midrst_head_valid: got %b required 1", bus.dec_valid); end
    total++; if (bus.dec_pc !== 11'h000) begin bad++; $display("FAIL midrst_head_pc: got %h required 000", bus.dec_pc); end
    next_cycle();
    total++; if (exp_q.size() != 1) begin bad++; $display("FAIL midrst_drain: got %0d pending required 1", exp_q.size()); end
    resetn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_replay();
    test_flush();
    test_redirect_full();
    test_pc_wrap();
    test_reset_midop();
    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch back end for the pipelined CPU: takes the program count from the PC register, presents it to the asynchronous instruction memory, and buffers returned instructions with their PC for decode. It is the driver of the PC's branch port: it asserts `branch_valid`/`branch_address` to redirect fetch on an execute-stage taken branch, and to replay the current address when the queue is full. The PC has no stall input, so replay is the only back-pressure path to it.

## Interface
- `AW`, 11: PC/address width; must match the PC register.
- `IW`, 32: instruction width.
- `DEPTH`, 4: queue entries; power of two, at least 2.

- `clk`  in  1  CPU clock.
- `resetn`  in  1  synchronous, active-low reset.
- `pc_cnt`  in  AW  current PC register value.
- `imem_addr`  out  AW  instruction memory address; equals `pc_cnt` combinationally.
- `imem_data`  in  IW  asynchronous read data for `imem_addr`, valid in the same cycle.
- `branch_valid`  out  1  load request to the PC.
- `branch_address`  out  AW  value the PC loads when `branch_valid` is 1.
- `ex_redirect`  in  1  execute stage resolved a taken branch this cycle.
- `ex_target`  in  AW  target of that branch.
- `dec_valid`  out  1  queue head is valid for decode.
- `dec_ready`  in  1  decode accepts the head this cycle.
- `dec_instr`  out  IW  head instruction.
- `dec_pc`  out  AW  head PC.

## Operation
- **Fetch slot:** every cycle with `resetn` high, the pair {`pc_cnt`, `imem_data`} is a push candidate.
- **`pop`:** `dec_valid && dec_ready`.
  - `dec_valid` = !empty && !`ex_redirect`. Decode never consumes wrong-path entries in a flush cycle.
- **Priority, highest first:**
  1. **`ex_redirect` = 1 (flush):**
     - the candidate is dropped and all entries are flushed (`wr_ptr`=`rd_ptr`, count 0);
     - `branch_valid`=1, `branch_address`=`ex_target`.
  2. **Queue full and no `pop` this cycle (replay):**
     - the candidate is dropped;
     - `branch_valid`=1, `branch_address`=`pc_cnt`, so the PC holds and the same address is re-fetched next cycle;
     - repeats every cycle until space frees.
  3. **Otherwise (push):**
     - the candidate is pushed, `branch_valid`=0;
     - `branch_address`=`ex_target` (don't-care, but defined).
- **Push and pop in the same cycle:**
  - allowed when full or non-empty;
  - count unchanged;
  - a full queue with a pop accepts the push (no replay).
- **Ordering:** entries leave in push order.
- **PC wrap:** 0x7FF followed by 0x000 is ordinary; the queue does not interpret PC values.
- **Pointers:**
  - `log2(DEPTH)+1` bits each; full when the MSBs differ and the LSBs are equal.
  - Both wrap modulo 2·DEPTH.
- **Reset (resetn=0), including mid-operation:**
  - pointers cleared, queue empty;
  - `branch_valid`=0 and `dec_valid`=0 while `resetn` is low;
  - stats counters cleared;
  - contents of the storage array are not reset.

## Timing
- Push in cycle N: the entry is visible on `dec_*` from cycle N+1. Latency is 1; there is no bypass.
- Throughput is 1 instruction per cycle with `dec_ready` held high.
- `branch_valid`/`branch_address` are combinational from `ex_redirect`, `ex_target`, `pc_cnt`, full state and `dec_ready`. The PC samples them at the next posedge.
- First cycle after reset release: `pc_cnt`=0 and it is pushed. Decode sees PC 0 one cycle later.
- Redirect in cycle N: the PC equals `ex_target` in N+1, and that instruction reaches `dec_*` in N+2.

## Configuration
- **`FETCH_STATS_EN` defined:** adds three 16-bit saturating counters, all cleared on reset:
  - `stat_fetched`: increments on each push;
  - `stat_replays`: increments on each replay cycle;
  - `stat_flushes`: increments on each `ex_redirect` cycle.
  
  Each counter has its own output port of the same name.
- **Undefined:** no counters and no ports; the rest of the behaviour is identical.

## Structure
- Package `fetch_pkg`:
  - default `AW`/`IW` localparams;
  - `fetch_entry_t` = {pc[AW], instr[IW]};
  - `FETCH_STAT_W`=16.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t` with push, pop, flush, full and empty. Flush has priority over push and pop.
- `fetch_queue` owns the redirect/replay priority logic, the `dec_valid` masking, and the optional stats.

## Test plan
1. **Reset and streaming:** reset 2 cycles, `dec_ready`=1, `imem_data`=addr+0x100 → `dec_pc` 0,1,2,… with `dec_instr` 0x100,0x101,… one per cycle; `branch_valid` stays 0.
2. **Fill and replay:** `dec_ready`=0, DEPTH=4 → PCs 0–3 are queued; from the 5th fetch cycle `branch_valid`=1 with `branch_address`=4 every cycle. Then raise `dec_ready` → `dec_pc` 0,1,2,3,4,5 with no gap or duplicate.
3. **Flush:** 3 entries queued, `ex_redirect`=1 with `ex_target`=0x200 → `dec_valid`=0 that cycle, `branch_address`=0x200, queue empty next cycle, next `dec_pc`=0x200.
4. **Redirect while full:** queue full, `dec_ready`=0, `ex_redirect`=1 with `ex_target`=0x050 → `branch_address`=0x050 (not the replay address), queue empty next cycle.
5. **PC wrap:** drive `pc_cnt` 0x7FE, 0x7FF, 0x000 → dequeued in that order with matching instructions.
6. **Reset mid-operation:** full queue with stats nonzero, `resetn`=0 for 1 cycle → `dec_valid`=0 and `branch_valid`=0, and the next push appears at head; with `FETCH_STATS_EN`, all counters read 0.
